// File: rtl/univ_shift_reg_pkg.sv
// ============================================================================
//  Module  : univ_shift_reg_pkg
//  Brief   : Mode encodings shared by univ_shift_reg, its bit cell and users.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package univ_shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ASR  = 3'b101;
    localparam logic [2:0] MODE_LOAD = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    // True for every mode that moves bits and therefore advances the counter.
    function automatic logic is_shift_mode(input logic [2:0] mode);
        return (mode >= MODE_SHL) && (mode <= MODE_ASR);
    endfunction

endpackage : univ_shift_reg_pkg

`default_nettype wire

// File: rtl/usr_bit_cell.sv
// ============================================================================
//  Module  : usr_bit_cell
//  Brief   : One register bit: 8:1 next-state mux feeding an async-reset flop.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module usr_bit_cell
    import univ_shift_reg_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [2:0] i_mode,
    input  logic       i_d,
    input  logic       i_shl,
    input  logic       i_shr,
    input  logic       i_rol,
    input  logic       i_ror,
    input  logic       i_asr,
    output logic       o_q
);

    logic r_q;
    logic w_next;

    always_comb begin
        w_next = r_q;
        case (i_mode)
            MODE_HOLD: w_next = r_q;
            MODE_SHL:  w_next = i_shl;
            MODE_SHR:  w_next = i_shr;
            MODE_ROL:  w_next = i_rol;
            MODE_ROR:  w_next = i_ror;
            MODE_ASR:  w_next = i_asr;
            MODE_LOAD: w_next = i_d;
            MODE_CLR:  w_next = 1'b0;
            default:   w_next = r_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= RST_BIT;
        end else if (i_en) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule : usr_bit_cell

`default_nettype wire

// File: rtl/univ_shift_reg.sv
// ============================================================================
//  Module  : univ_shift_reg
//  Brief   : WIDTH-bit universal shift register with saturating shift counter.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sin_l,
    input  logic             i_sin_r,
    output logic [WIDTH-1:0] o_q,
    output logic             o_sout_msb,
    output logic             o_sout_lsb,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_asr;
    logic [CNT_W-1:0] r_cnt;

    // Candidate next values for each mode; bit i of each feeds cell i.
    assign w_shl = {w_q[WIDTH-2:0], i_sin_l};
    assign w_shr = {i_sin_r, w_q[WIDTH-1:1]};
    assign w_rol = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
    assign w_ror = {w_q[0], w_q[WIDTH-1:1]};
    assign w_asr = {w_q[WIDTH-1], w_q[WIDTH-1:1]};

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            usr_bit_cell #(
                .RST_BIT (RST_VAL[gi])
            ) u_cell (
                .i_clk  (i_clk),
                .i_rst  (i_rst),
                .i_en   (i_en),
                .i_mode (i_mode),
                .i_d    (i_d[gi]),
                .i_shl  (w_shl[gi]),
                .i_shr  (w_shr[gi]),
                .i_rol  (w_rol[gi]),
                .i_ror  (w_ror[gi]),
                .i_asr  (w_asr[gi]),
                .o_q    (w_q[gi])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if ((i_mode == MODE_LOAD) || (i_mode == MODE_CLR)) begin
                r_cnt <= '0;
            end else if (is_shift_mode(i_mode) && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_q        = w_q;
    assign o_sout_msb = w_q[WIDTH-1];
    assign o_sout_lsb = w_q[0];
    assign o_cnt      = r_cnt;
    assign o_zero     = (w_q == '0);

endmodule : univ_shift_reg

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
//  Module  : tb_univ_shift_reg
//  Brief   : Scoreboard bench for univ_shift_reg against a behavioural model.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_univ_shift_reg;
    import univ_shift_reg_pkg::*;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] q,  q2;
    logic       msb, lsb, zero, msb2, lsb2, zero2;
    logic [3:0] cnt, cnt2;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] m_q;
    int         m_cnt;

    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_d(d),
        .i_sin_l(sl), .i_sin_r(sr), .o_q(q), .o_sout_msb(msb),
        .o_sout_lsb(lsb), .o_cnt(cnt), .o_zero(zero)
    );

    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h5A), .CNT_W(4)) dut5a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_d(d),
        .i_sin_l(sl), .i_sin_r(sr), .o_q(q2), .o_sout_msb(msb2),
        .o_sout_lsb(lsb2), .o_cnt(cnt2), .o_zero(zero2)
    );

    // Posedges at 5, 15, 25 ... so t = 555 ns is a rising edge; clock starts
    // high instead, giving posedges at 10, 20 ... and leaving 555 mid-cycle.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the register written from the operation table, not the RTL.
    task automatic model_step(input logic e, input logic [2:0] md, input logic [7:0] dd,
                              input logic l, input logic r);
        if (!e) return;
        case (md)
            MODE_SHL:  m_q = (m_q << 1) | {7'd0, l};
            MODE_SHR:  m_q = (m_q >> 1) | {r, 7'd0};
            MODE_ROL:  m_q = (m_q << 1) | (m_q >> 7);
            MODE_ROR:  m_q = (m_q >> 1) | (m_q << 7);
            MODE_ASR:  m_q = 8'($signed(m_q) >>> 1);
            MODE_LOAD: m_q = dd;
            MODE_CLR:  m_q = 8'h00;
            default:   m_q = m_q;
        endcase
        if (md == MODE_LOAD || md == MODE_CLR) m_cnt = 0;
        else if (md != MODE_HOLD)              m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
    endtask

    task automatic step(input logic e, input logic [2:0] md, input logic [7:0] dd,
                        input logic l, input logic r);
        exp_t x;
        @(negedge clk);
        en = e; mode = md; d = dd; sl = l; sr = r;
        model_step(e, md, dd, l, r);
        x.q   = m_q;
        x.cnt = 4'(m_cnt);
        sb.push_back(x);
    endtask

    task automatic stepc(input logic e, input logic [2:0] md, input logic [7:0] dd,
                         input logic l, input logic r, input string name,
                         input logic [7:0] eq, input logic [3:0] ec);
        step(e, md, dd, l, r);
        @(posedge clk);
        #2;
        chk({name, "_q"}, 32'(q), 32'(eq));
        chk({name, "_cnt"}, 32'(cnt), 32'(ec));
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                n_tests++;
                if (q !== x.q || cnt !== x.cnt || msb !== x.q[7] || lsb !== x.q[0]
                    || zero !== (x.q == 8'h00)) begin
                    n_fail++;
                    $display("FAIL scoreboard: got q=%h cnt=%0d msb=%b lsb=%b zero=%b expected q=%h cnt=%0d at %0t",
                             q, cnt, msb, lsb, zero, x.q, x.cnt, $time);
                end
            end
        end
    end

    initial begin : stim
        int wait_cnt;
        rst = 1'b1; en = 1'b0; mode = MODE_HOLD; d = 8'h00; sl = 1'b0; sr = 1'b0;
        m_q = 8'h00; m_cnt = 0;
        #3;
        chk("rst_q",     32'(q),     32'h00);
        chk("rst_cnt",   32'(cnt),   32'h0);
        chk("rst_zero",  32'(zero),  32'h1);
        chk("rst5a_q",   32'(q2),    32'h5A);
        chk("rst5a_zero",32'(zero2), 32'h0);
        chk("rst5a_msb", 32'(msb2),  32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Load 3C, then idle until a mid-cycle reset at 555 ns.
        stepc(1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0, "load3c", 8'h3C, 4'd0);
        step(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        while ($time + 10 < 555) step(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        #(555 - $time);
        rst = 1'b1;
        m_q = 8'h00; m_cnt = 0;
        #2;
        chk("async_rst_q",   32'(q),   32'h00);
        chk("async_rst_cnt", 32'(cnt), 32'h0);
        en = 1'b1; mode = MODE_LOAD; d = 8'hFF;
        @(posedge clk);
        #2;
        chk("rst_held_q", 32'(q), 32'h00);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b0;

        stepc(1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0, "loadA5", 8'hA5, 4'd0);
        stepc(1'b1, MODE_SHL,  8'h00, 1'b1, 1'b0, "shl",    8'h4B, 4'd1);
        stepc(1'b1, MODE_SHR,  8'h00, 1'b0, 1'b1, "shr",    8'hA5, 4'd2);

        stepc(1'b1, MODE_LOAD, 8'h81, 1'b1, 1'b1, "load81", 8'h81, 4'd0);
        stepc(1'b1, MODE_ROR,  8'h00, 1'b1, 1'b1, "ror1",   8'hC0, 4'd1);
        for (int i = 0; i < 6; i++) step(1'b1, MODE_ROR, 8'h00, 1'b0, 1'b1);
        stepc(1'b1, MODE_ROR,  8'h00, 1'b0, 1'b0, "ror8",   8'h81, 4'd8);
        stepc(1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0, "rol",    8'h03, 4'd9);

        stepc(1'b1, MODE_LOAD, 8'h80, 1'b0, 1'b0, "load80", 8'h80, 4'd0);
        stepc(1'b1, MODE_ASR,  8'h00, 1'b0, 1'b0, "asr1",   8'hC0, 4'd1);
        stepc(1'b1, MODE_ASR,  8'h00, 1'b0, 1'b0, "asr2",   8'hE0, 4'd2);
        stepc(1'b1, MODE_LOAD, 8'h40, 1'b0, 1'b0, "load40", 8'h40, 4'd0);
        stepc(1'b1, MODE_ASR,  8'h00, 1'b1, 1'b1, "asr_pos",8'h20, 4'd1);

        for (int i = 0; i < 4; i++) step(1'b0, MODE_LOAD, 8'hFF, 1'b1, 1'b1);
        stepc(1'b0, MODE_LOAD, 8'hFF, 1'b1, 1'b1, "en_gate", 8'h20, 4'd1);
        stepc(1'b1, MODE_CLR,  8'hFF, 1'b1, 1'b1, "clr",     8'h00, 4'd0);
        chk("clr_zero", 32'(zero), 32'h1);

        for (int i = 0; i < 19; i++) step(1'b1, MODE_SHL, 8'h00, 1'($urandom), 1'b0);
        step(1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        chk("sat_cnt", 32'(cnt), 32'd15);
        stepc(1'b1, MODE_LOAD, 8'h5C, 1'b0, 1'b0, "load_after_sat", 8'h5C, 4'd0);

        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 9) != 0), 3'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom));
        step(1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #3;
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        @(negedge clk);
        d = 8'h11; mode = MODE_LOAD; en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("final_rst_q",      32'(q),     32'h00);
        chk("final_rst5a_q",    32'(q2),    32'h5A);
        chk("final_rst5a_zero", 32'(zero2), 32'h0);
        chk("final_rst5a_cnt",  32'(cnt2),  32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_univ_shift_reg

`default_nettype wire
